// File: rtl/burst_mem_pkg.sv
// Shared constants, FSM state type and beat helper for the burst memory
// responder. One line is 256 bits carried as four 64-bit beats, beat 0 being
// the least-significant lane.
package burst_mem_pkg;
  localparam int BEATS       = 4;
  localparam int BEAT_W      = 64;
  localparam int LINE_W      = BEATS * BEAT_W;
  localparam int OFFSET_BITS = 5;
  localparam int BEAT_IDX_W  = $clog2(BEATS);

  typedef enum logic [1:0] {IDLE, WAIT, BURST, DONE} resp_state_t;

  // Lane k of a line: bits [64k+63:64k].
  function automatic logic [BEAT_W-1:0] beat_slice(input logic [LINE_W-1:0] line,
                                                   input logic [BEAT_IDX_W-1:0] k);
    return line[k*BEAT_W +: BEAT_W];
  endfunction
endpackage

// File: rtl/burst_mem_line_store.sv
// Line-organised backing store.
// Ports: clk; index/lane/rdata = asynchronous lane read; lane_we/wdata =
// synchronous lane write at (index, lane); bd_we/bd_index/bd_line =
// synchronous whole-line backdoor write. The two writes never coincide
// (backdoor only in IDLE, lane writes only in BURST); backdoor wins anyway.
// Contents are not reset.
module line_store
  import burst_mem_pkg::*;
#(
  parameter int IDX_BITS = 8
) (
  input  logic                  clk,
  input  logic [IDX_BITS-1:0]   index,
  input  logic [BEAT_IDX_W-1:0] lane,
  output logic [BEAT_W-1:0]     rdata,
  input  logic                  lane_we,
  input  logic [BEAT_W-1:0]     wdata,
  input  logic                  bd_we,
  input  logic [IDX_BITS-1:0]   bd_index,
  input  logic [LINE_W-1:0]     bd_line
);
  logic [BEATS-1:0][BEAT_W-1:0] mem [2**IDX_BITS];

  assign rdata = beat_slice(mem[index], lane);

  always_ff @(posedge clk) begin
    if (bd_we)        mem[bd_index]    <= bd_line;
    else if (lane_we) mem[index][lane] <= wdata;
  end
endmodule

// File: rtl/burst_mem_responder.sv
// Memory-side responder for the 64-bit x 4-beat line burst protocol.
// Ports: clk, reset_n (async low); mem_read/mem_write/mem_address/mem_wdata
// from the initiator; mem_resp/mem_rdata beat responses; busy (not IDLE);
// protocol_error (sticky); bd_we/bd_index/bd_line backdoor preload.
// Flow: IDLE -> WAIT (LATENCY cycles) -> BURST (4 beats) -> DONE -> IDLE.
module burst_mem_responder
  import burst_mem_pkg::*;
#(
  parameter int IDX_BITS = 8,
  parameter int LATENCY  = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                mem_read,
  input  logic                mem_write,
  input  logic [31:0]         mem_address,
  input  logic [BEAT_W-1:0]   mem_wdata,
  output logic                mem_resp,
  output logic [BEAT_W-1:0]   mem_rdata,
  output logic                busy,
  output logic                protocol_error,
  input  logic                bd_we,
  input  logic [IDX_BITS-1:0] bd_index,
  input  logic [LINE_W-1:0]   bd_line
);
  localparam int CNT_W = $clog2(LATENCY + 1);
  localparam int TAG_W = 32 - OFFSET_BITS;

  resp_state_t           state, state_n;
  logic [CNT_W-1:0]      cnt, cnt_n;
  logic [BEAT_IDX_W-1:0] beat, beat_n;
  logic                  op_wr, op_wr_n;
  logic [TAG_W-1:0]      line_addr, line_addr_n;
  logic                  err, err_n;
  logic                  lane_we;
  logic [BEAT_W-1:0]     store_rdata;
  logic                  unused_offset;

  // Byte offset within the line carries no meaning here.
  assign unused_offset = ^mem_address[OFFSET_BITS-1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      beat      <= '0;
      op_wr     <= 1'b0;
      line_addr <= '0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      beat      <= beat_n;
      op_wr     <= op_wr_n;
      line_addr <= line_addr_n;
      err       <= err_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    beat_n      = beat;
    op_wr_n     = op_wr;
    line_addr_n = line_addr;
    err_n       = err;
    lane_we     = 1'b0;
    case (state)
      IDLE: begin
        if (mem_read && mem_write) begin
          err_n = 1'b1;
        end else if (mem_read || mem_write) begin
          state_n     = WAIT;
          op_wr_n     = mem_write;
          line_addr_n = mem_address[31:OFFSET_BITS];
          cnt_n       = CNT_W'(LATENCY - 1);
          beat_n      = '0;
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_n = BURST;
          beat_n  = '0;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      BURST: begin
        // Write beats commit even if the initiator misbehaves; the
        // transaction always finishes on the latched op and index.
        lane_we = op_wr;
        beat_n  = beat + 1'b1;
        if (beat == BEAT_IDX_W'(BEATS - 1)) state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    if (state == WAIT || state == BURST) begin
      if ((op_wr ? !mem_write : !mem_read) ||
          (op_wr ? mem_read : mem_write) ||
          (mem_address[31:OFFSET_BITS] != line_addr))
        err_n = 1'b1;
    end
    if (state != IDLE && bd_we) err_n = 1'b1;
  end

  line_store #(.IDX_BITS(IDX_BITS)) u_store (
    .clk      (clk),
    .index    (line_addr[IDX_BITS-1:0]),
    .lane     (beat),
    .rdata    (store_rdata),
    .lane_we  (lane_we),
    .wdata    (mem_wdata),
    .bd_we    (bd_we && state == IDLE),
    .bd_index (bd_index),
    .bd_line  (bd_line)
  );

  assign mem_resp       = (state == BURST);
  assign mem_rdata      = (state == BURST && !op_wr) ? store_rdata : '0;
  assign busy           = (state != IDLE);
  assign protocol_error = err;
endmodule
